vga_pattern_seq: RTL and testbench

Frame-synchronous controller that selects which test pattern the VGA pattern generator draws.
- Runs in the pixel clock domain, alongside the pattern datapath.
- Watches vsync to find frame boundaries.
- Applies host commands (next / prev / set) and an optional timed auto-advance.
- Changes pattern_sel only at a frame boundary, so no frame is ever drawn with a mixed pattern.

---
 rtl/vga_pattern_pkg.sv | 19 +
 rtl/vga_vsync_edge.sv | 27 ++
 rtl/vga_pattern_seq.sv | 143 ++++++++++++++
 tb/tb_vga_pattern_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_pkg.sv
// Shared types and defaults for the VGA test-pattern generator and its sequencer.
package vga_pattern_pkg;

    localparam int DEFAULT_NUM_PATTERNS = 4;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_NEXT = 2'd1,
        OP_PREV = 2'd2,
        OP_SET  = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/vga_vsync_edge.sv
// Registers vsync and flags the first cycle it reaches its active level (frame start).
module vga_vsync_edge #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic frame_start
);

    localparam logic ACTIVE_LEVEL = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic vsync_q;

    // Resetting to the active level suppresses a false frame start when vsync
    // is already active as reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= ACTIVE_LEVEL;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign frame_start = (vsync == ACTIVE_LEVEL) && (vsync_q != ACTIVE_LEVEL);

endmodule

// File: rtl/vga_pattern_seq.sv
// Frame-synchronous pattern selector: host commands and timed auto-advance
// take effect only at a frame start so no frame mixes two patterns.
module vga_pattern_seq
    import vga_pattern_pkg::*;
#(
    parameter int NUM_PATTERNS       = DEFAULT_NUM_PATTERNS,
    parameter int SEL_WIDTH          = $clog2(NUM_PATTERNS),
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int FCNT_WIDTH         = $clog2(FRAMES_PER_PATTERN + 1),
    parameter int VSYNC_ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  vga_vsync,
    input  logic                  auto_en,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    output logic [SEL_WIDTH-1:0]  pattern_sel,
    output logic                  pattern_stb,
    output logic [FCNT_WIDTH-1:0] frame_cnt,
    output logic [1:0]            dbg_state
);

    localparam logic [SEL_WIDTH-1:0]  LAST_SEL = SEL_WIDTH'(NUM_PATTERNS - 1);
    localparam logic [FCNT_WIDTH-1:0] FCNT_MAX = FCNT_WIDTH'(FRAMES_PER_PATTERN);
    localparam logic [FCNT_WIDTH-1:0] AUTO_AT  = FCNT_WIDTH'(FRAMES_PER_PATTERN - 1);

    // Handshake: a command transfers on a rising clk edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on state, never on cmd_valid.

    state_t                 state_q, state_d;
    cmd_op_t                op_in;
    cmd_op_t                pend_op_q;
    logic [SEL_WIDTH-1:0]   pend_sel_q;
    cmd_op_t                apply_op;
    logic [SEL_WIDTH-1:0]   sel_d;
    logic                   changed;
    logic                   fs;
    logic                   auto_q;
    logic                   auto_rise;
    logic                   counting;
    logic                   latch_cmd;

    vga_vsync_edge #(
        .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_vsync_edge (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vga_vsync),
        .frame_start (fs)
    );

    assign op_in     = cmd_op_t'(cmd_op);
    assign cmd_ready = (state_q == RUN);
    assign dbg_state = state_q;
    assign auto_rise = auto_en && !auto_q;
    assign latch_cmd = en && (state_q == RUN) && cmd_valid && (op_in != OP_NOP);
    assign counting  = en && fs && ((state_q == RUN) || (state_q == PEND));

    // A command accepted in the fs cycle itself is only latched here; it is
    // applied from PEND at the following frame start.
    always_comb begin
        state_d  = state_q;
        apply_op = OP_NOP;
        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (fs && auto_en && (frame_cnt == AUTO_AT)) begin
                    apply_op = OP_NEXT;
                end
                if (cmd_valid && (op_in != OP_NOP)) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (fs) begin
                    apply_op = pend_op_q;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!en) begin
            state_d  = IDLE;
            apply_op = OP_NOP;
        end
    end

    always_comb begin
        sel_d = pattern_sel;
        case (apply_op)
            OP_NEXT: sel_d = (pattern_sel == LAST_SEL) ? '0 : pattern_sel + SEL_WIDTH'(1);
            OP_PREV: sel_d = (pattern_sel == '0) ? LAST_SEL : pattern_sel - SEL_WIDTH'(1);
            OP_SET: begin
                // Out-of-range targets leave the selection untouched.
                if (32'(pend_sel_q) < NUM_PATTERNS) begin
                    sel_d = pend_sel_q;
                end
            end
            default: sel_d = pattern_sel;
        endcase
    end

    assign changed = (sel_d != pattern_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_op_q   <= OP_NOP;
            pend_sel_q  <= '0;
            pattern_sel <= '0;
            pattern_stb <= 1'b0;
            frame_cnt   <= '0;
            auto_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            auto_q      <= auto_en;
            pattern_sel <= sel_d;
            pattern_stb <= changed;

            if (latch_cmd) begin
                pend_op_q  <= op_in;
                pend_sel_q <= cmd_sel;
            end else if (!en || (state_q == PEND && fs)) begin
                pend_op_q <= OP_NOP;
            end

            if (changed || auto_rise) begin
                frame_cnt <= '0;
            end else if (counting && (frame_cnt != FCNT_MAX)) begin
                frame_cnt <= frame_cnt + FCNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_seq.sv
// Directed bench for vga_pattern_seq with a strobe scoreboard of expected selections.
module tb_vga_pattern_seq;
    import vga_pattern_pkg::*;

    localparam int SW = 3;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          vga_vsync;
    logic          auto_en;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [SW-1:0] cmd_sel;
    logic [SW-1:0] pattern_sel;
    logic          pattern_stb;
    logic [FW-1:0] frame_cnt;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] mon_exp;

    int auto_cnt[10] = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1};
    int auto_sel[10] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3};

    vga_pattern_seq #(
        .NUM_PATTERNS       (4),
        .SEL_WIDTH          (SW),
        .FRAMES_PER_PATTERN (3),
        .FCNT_WIDTH         (FW),
        .VSYNC_ACTIVE_LOW   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .vga_vsync   (vga_vsync),
        .auto_en     (auto_en),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_sel     (cmd_sel),
        .pattern_sel (pattern_sel),
        .pattern_stb (pattern_stb),
        .frame_cnt   (frame_cnt),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send_cmd(input cmd_op_t op, input logic [SW-1:0] sel);
        int waited = 0;
        while (cmd_ready !== 1'b1 && waited < 64) begin
            cycle();
            waited++;
        end
        checks++;
        assert (cmd_ready === 1'b1) else begin
            errors++;
            $error("FAIL cmd_ready_timeout: observed %b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cycle();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_sel   = '0;
    endtask

    // Active-low vsync pulse of three cycles followed by three inactive cycles.
    task automatic frame();
        vga_vsync = 1'b0;
        cycle(3);
        vga_vsync = 1'b1;
        cycle(3);
    endtask

    always @(negedge clk) begin
        if (pattern_stb === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL stb_unexpected: observed strobe with sel %0d expected no strobe", pattern_sel);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                assert (pattern_sel === mon_exp) else begin
                    errors++;
                    $error("FAIL stb_sel: observed %0d expected %0d", pattern_sel, mon_exp);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        vga_vsync = 1'b0;
        auto_en   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_sel   = '0;
        cycle(3);
        check("rst_sel", pattern_sel, 0);
        check("rst_stb", pattern_stb, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_state", dbg_state, IDLE);

        // Release with vsync still active: no frame start yet.
        rst = 1'b0;
        cycle();
        check("rel_state", dbg_state, RUN);
        check("rel_ready", cmd_ready, 1);
        check("rel_stb", pattern_stb, 0);
        cycle(2);
        check("rel_cnt_active", frame_cnt, 0);
        vga_vsync = 1'b1;
        cycle(3);
        check("rel_cnt_inactive", frame_cnt, 0);
        frame();
        check("first_fs_cnt", frame_cnt, 1);

        send_cmd(OP_NOP, 0);
        check("nop_state", dbg_state, RUN);
        check("nop_ready", cmd_ready, 1);

        // NEXT mid-frame, inspected cycle by cycle around the frame start.
        send_cmd(OP_NEXT, 0);
        check("next_ready_low", cmd_ready, 0);
        check("next_state_pend", dbg_state, PEND);
        cycle(5);
        check("next_before_fs", pattern_sel, 0);
        exp_q.push_back(3'd1);
        vga_vsync = 1'b0;
        cycle();
        check("next_stb_hi", pattern_stb, 1);
        check("next_sel", pattern_sel, 1);
        check("next_cnt_clr", frame_cnt, 0);
        cycle();
        check("next_stb_lo", pattern_stb, 0);
        check("next_ready_back", cmd_ready, 1);
        cycle();
        vga_vsync = 1'b1;
        cycle(3);

        exp_q.push_back(3'd0);
        send_cmd(OP_PREV, 0);
        frame();
        check("prev_sel", pattern_sel, 0);
        exp_q.push_back(3'd3);
        send_cmd(OP_PREV, 0);
        frame();
        check("prev_wrap", pattern_sel, 3);
        exp_q.push_back(3'd0);
        send_cmd(OP_NEXT, 0);
        frame();
        check("next_wrap", pattern_sel, 0);

        send_cmd(OP_SET, 3'd5);
        check("set_oor_accepted", cmd_ready, 0);
        frame();
        check("set_oor_sel", pattern_sel, 0);
        check("set_oor_cnt", frame_cnt, 1);
        exp_q.push_back(3'd2);
        send_cmd(OP_SET, 3'd2);
        frame();
        check("set_sel", pattern_sel, 2);
        check("set_cnt", frame_cnt, 0);
        send_cmd(OP_SET, 3'd2);
        frame();
        check("set_same_sel", pattern_sel, 2);
        check("set_same_cnt", frame_cnt, 1);
        repeat (4) frame();
        check("cnt_saturate", frame_cnt, 3);
        check("no_auto_sel", pattern_sel, 2);

        exp_q.push_back(3'd0);
        send_cmd(OP_SET, 3'd0);
        frame();
        check("set0_sel", pattern_sel, 0);
        frame();
        check("pre_auto_cnt", frame_cnt, 1);
        auto_en = 1'b1;
        cycle(2);
        check("auto_rise_clear", frame_cnt, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) send_cmd(OP_NEXT, 0);
            if (i == 2 || i == 5 || i == 8) exp_q.push_back(SW'(auto_sel[i]));
            frame();
            check($sformatf("auto_sel_f%0d", i + 1), pattern_sel, auto_sel[i]);
            check($sformatf("auto_cnt_f%0d", i + 1), frame_cnt, auto_cnt[i]);
        end
        auto_en = 1'b0;

        // Drop enable with a command pending.
        send_cmd(OP_NEXT, 0);
        cycle(2);
        en = 1'b0;
        cycle();
        check("en_drop_state", dbg_state, IDLE);
        check("en_drop_ready", cmd_ready, 0);
        frame();
        check("en_drop_sel", pattern_sel, 3);
        check("idle_cnt_frozen", frame_cnt, 1);
        en = 1'b1;
        cycle();
        check("reenable_state", dbg_state, RUN);
        frame();
        check("reenable_sel", pattern_sel, 3);
        check("reenable_cnt", frame_cnt, 2);

        // Reset while a command is pending.
        send_cmd(OP_NEXT, 0);
        check("rst_pend_state", dbg_state, PEND);
        rst = 1'b1;
        cycle();
        check("rst2_sel", pattern_sel, 0);
        check("rst2_cnt", frame_cnt, 0);
        check("rst2_state", dbg_state, IDLE);
        check("rst2_ready", cmd_ready, 0);
        rst = 1'b0;
        cycle();
        frame();
        check("rst_pend_lost", pattern_sel, 0);
        check("rst_pend_cnt", frame_cnt, 1);

        cycle(2);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL exp_q_drain: observed %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
